dcache_wb: RTL and testbench

DCACHE_WB -- requirements
Module: dcache_wb

---
 rtl/dcache_wb_if.sv | 16 +
 rtl/dcache_wb.sv | 134 +++++++++++++
 tb/tb_dcache_wb.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_wb_if.sv
// dcache_wb_if: processor request/response and word-memory bus of the write-back data cache.
interface dcache_wb_if;
  logic        read_request, write_request, flush, response, flush_done;
  logic [31:0] addr, write_data, read_data;
  logic [3:0]  write_strb;
  logic        memory_read_request, memory_write_request, memory_response;
  logic [31:0] memory_addr, memory_write_data, memory_read_data;
  modport master (
    output read_request, write_request, addr, write_data, write_strb, flush, memory_response, memory_read_data,
    input  response, read_data, flush_done, memory_read_request, memory_write_request, memory_addr, memory_write_data
  );
  modport slave (
    input  read_request, write_request, addr, write_data, write_strb, flush, memory_response, memory_read_data,
    output response, read_data, flush_done, memory_read_request, memory_write_request, memory_addr, memory_write_data
  );
endinterface

// File: rtl/dcache_wb.sv
// dcache_wb: direct-mapped write-back write-allocate data cache with line refill, victim writeback and flush.
module dcache_wb #(
  parameter int CACHE_SIZE = 1024,
  parameter int LINE_WORDS = 4
) (
  input logic       clk,
  input logic       rst_n,
  dcache_wb_if.slave bus
);
  localparam int LINES = CACHE_SIZE / (4 * LINE_WORDS);
  localparam int WB    = $clog2(LINE_WORDS);
  localparam int CW    = WB > 0 ? WB : 1;
  localparam int IB    = $clog2(LINES);
  localparam int TB    = 30 - WB - IB;
  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, FLUSH} state_t;
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IB-1:0]    fidx_q, fidx_d;
  logic             fl_q, fl_d;
  logic [LINES-1:0] valid_q, valid_d, dirty_q, dirty_d;
  logic [TB-1:0]    tag_mem [LINES];
  logic [31:0]      data_mem [LINES][LINE_WORDS];
  logic [IB-1:0]    idx, line;
  logic [CW-1:0]    word, we_word;
  logic [TB-1:0]    tag;
  logic [31:0]      cur, mask, we_val, wb_addr, rf_addr;
  logic             req, hit, last, we, tag_we, mem_rd, mem_wr;
  assign idx  = IB'(bus.addr >> (WB + 2));
  assign word = CW'((bus.addr >> 2) & (LINE_WORDS - 1));
  assign tag  = TB'(bus.addr >> (WB + IB + 2));
  assign req  = bus.read_request | bus.write_request;
  assign hit  = valid_q[idx] && tag_mem[idx] == tag;
  assign line = fl_q ? fidx_q : idx;
  assign last = cnt_q == CW'(LINE_WORDS - 1);
  assign cur  = data_mem[idx][word];
  assign mask = {{8{bus.write_strb[3]}}, {8{bus.write_strb[2]}}, {8{bus.write_strb[1]}}, {8{bus.write_strb[0]}}};
  // Writeback targets the victim (or flushed) line; refill targets the requested line.
  assign wb_addr = (32'({tag_mem[line], line}) << (WB + 2)) | (32'(cnt_q) << 2);
  assign rf_addr = (32'({tag, idx}) << (WB + 2)) | (32'(cnt_q) << 2);
  assign mem_wr  = state_q == WRITEBACK;
  assign mem_rd  = state_q == REFILL;
  assign bus.memory_write_request = mem_wr;
  assign bus.memory_read_request  = mem_rd;
  assign bus.memory_addr          = mem_wr ? wb_addr : mem_rd ? rf_addr : 32'h0;
  assign bus.memory_write_data    = mem_wr ? data_mem[line][cnt_q] : 32'h0;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fidx_d  = fidx_q;
    fl_d    = fl_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
    we      = 1'b0;
    tag_we  = 1'b0;
    we_word = word;
    we_val  = (bus.write_data & mask) | (cur & ~mask);
    bus.response   = 1'b0;
    bus.read_data  = 32'h0;
    bus.flush_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (req && hit) begin
          bus.response  = 1'b1;
          bus.read_data = cur;
          we            = bus.write_request;
          dirty_d[idx]  = dirty_q[idx] | bus.write_request;
        end else if (req) begin
          cnt_d   = '0;
          fl_d    = 1'b0;
          state_d = valid_q[idx] && dirty_q[idx] ? WRITEBACK : REFILL;
        end else if (bus.flush) begin
          fidx_d  = '0;
          fl_d    = 1'b1;
          state_d = FLUSH;
        end
      end
      WRITEBACK: begin
        if (bus.memory_response) begin
          cnt_d = last ? '0 : cnt_q + 1'b1;
          if (last && fl_q) dirty_d[line] = 1'b0;
          if (last) state_d = fl_q ? FLUSH : REFILL;
        end
      end
      REFILL: begin
        if (bus.memory_response) begin
          we      = 1'b1;
          we_word = cnt_q;
          we_val  = bus.memory_read_data;
          cnt_d   = last ? '0 : cnt_q + 1'b1;
          tag_we  = last;
          if (last) begin
            valid_d[idx] = 1'b1;
            dirty_d[idx] = 1'b0;
            state_d      = IDLE;
          end
        end
      end
      default: begin
        if (valid_q[fidx_q] && dirty_q[fidx_q]) begin
          cnt_d   = '0;
          state_d = WRITEBACK;
        end else if (fidx_q == IB'(LINES - 1)) begin
          bus.flush_done = 1'b1;
          fl_d           = 1'b0;
          state_d        = IDLE;
        end else begin
          fidx_d = fidx_q + 1'b1;
        end
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fidx_q  <= '0;
      fl_q    <= 1'b0;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fidx_q  <= fidx_d;
      fl_q    <= fl_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end
  // Tag and data arrays need no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if (we) data_mem[idx][we_word] <= we_val;
    if (tag_we) tag_mem[idx] <= tag;
  end
endmodule

// File: tb/tb_dcache_wb.sv
// tb_dcache_wb: randomized scoreboard bench for dcache_wb with a word-memory responder and a line-level cache model.
module tb_dcache_wb;
  localparam int LW = 4;
  localparam int LINES = 64;
  typedef struct {
    int          kind;
    logic [31:0] data;
    int          nrd;
    int          nwr;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  dcache_wb_if bus();
  dcache_wb #(.CACHE_SIZE(1024), .LINE_WORDS(LW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  exp_t        expq[$];
  logic [31:0] mem [bit [31:0]];
  logic [31:0] pv  [bit [31:0]];
  bit          r_valid [LINES];
  bit          r_dirty [LINES];
  int          r_tag   [LINES];
  bit [31:0]   rd_log[$], wr_log[$];
  int checks = 0, errors = 0;
  int rd_cnt = 0, wr_cnt = 0, rd_mark = 0, wr_mark = 0;
  int lat_lo = 0, lat_hi = 2;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask
  function automatic logic [31:0] memval(input bit [31:0] a);
    return mem.exists(a) ? mem[a] : (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction
  function automatic logic [31:0] expval(input bit [31:0] a);
    return pv.exists(a) ? pv[a] : memval(a);
  endfunction
  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (d & m) | (o & ~m);
  endfunction
  task automatic model_reset();
    for (int i = 0; i < LINES; i++) begin
      r_valid[i] = 1'b0;
      r_dirty[i] = 1'b0;
    end
    pv.delete();
  endtask
  task automatic issue(input bit rd, input bit wr, input bit [31:0] a, input logic [31:0] d, input logic [3:0] s);
    exp_t e;
    int   i, t;
    bit   h;
    i = int'((a >> 4) & 32'd63);
    t = int'(a >> 10);
    h = r_valid[i] && r_tag[i] == t;
    e.kind = wr ? 1 : 0;
    e.data = expval(a);
    e.nrd  = h ? 0 : LW;
    e.nwr  = (!h && r_valid[i] && r_dirty[i]) ? LW : 0;
    if (!h) begin
      r_valid[i] = 1'b1;
      r_tag[i]   = t;
      r_dirty[i] = 1'b0;
    end
    if (wr) begin
      r_dirty[i] = 1'b1;
      pv[a] = merge(e.data, d, s);
    end
    expq.push_back(e);
    bus.read_request  = rd;
    bus.write_request = wr;
    bus.addr          = a;
    bus.write_data    = d;
    bus.write_strb    = s;
  endtask
  task automatic wait_done(input bit fl, output int cyc);
    bit got = 1'b0;
    cyc = 0;
    for (int c = 1; c <= 400 && !got; c++) begin
      @(negedge clk);
      cyc = c;
      got = fl ? bus.flush_done : bus.response;
    end
    chk(fl ? "flush_timeout" : "response_timeout", {31'b0, got}, 1);
    @(posedge clk);
    #1;
    bus.read_request  = 1'b0;
    bus.write_request = 1'b0;
    bus.flush         = 1'b0;
  endtask
  task automatic do_flush();
    exp_t e;
    int   cyc;
    e.kind = 2;
    e.data = 32'h0;
    e.nrd  = 0;
    e.nwr  = 0;
    for (int i = 0; i < LINES; i++) begin
      if (r_valid[i] && r_dirty[i]) e.nwr += LW;
      r_dirty[i] = 1'b0;
    end
    expq.push_back(e);
    bus.flush = 1'b1;
    wait_done(1'b1, cyc);
  endtask
  task automatic chk_log(input string name, input bit [31:0] q[$], input bit [31:0] base);
    bit [31:0] bad = 0;
    if (q.size() != LW) bad = 32'hFFFF_0000 | q.size();
    else for (int k = 0; k < LW; k++) if (q[k] != base + 4 * k && bad == 0) bad = q[k];
    chk(name, bad, 0);
  endtask
  // Memory responder: random latency, checks request stability and writeback data.
  initial begin
    int          wl = -1;
    bit [31:0]   la = 0;
    logic        lrd = 1'b0;
    bus.memory_response  = 1'b0;
    bus.memory_read_data = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      bus.memory_response  = 1'b0;
      bus.memory_read_data = 32'h0;
      if (!rst_n || !(bus.memory_read_request || bus.memory_write_request)) begin
        wl = -1;
        continue;
      end
      if (wl < 0) begin
        wl  = $urandom_range(lat_hi, lat_lo);
        la  = bus.memory_addr;
        lrd = bus.memory_read_request;
      end else begin
        chk("mem_addr_stable", bus.memory_addr, la);
        chk("mem_req_stable", {31'b0, bus.memory_read_request}, {31'b0, lrd});
      end
      if (wl == 0) begin
        bus.memory_response = 1'b1;
        if (lrd) begin
          bus.memory_read_data = memval(la);
          rd_log.push_back(la);
          rd_cnt++;
        end else begin
          chk("writeback_data", bus.memory_write_data, expval(la));
          mem[la] = bus.memory_write_data;
          wr_log.push_back(la);
          wr_cnt++;
        end
        wl = -1;
      end else begin
        wl--;
      end
    end
  end
  // Monitor: pops the scoreboard whenever the cache completes a request or flush.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("mem_req_exclusive", {31'b0, bus.memory_read_request & bus.memory_write_request}, 0);
      if (!bus.memory_read_request && !bus.memory_write_request) begin
        chk("idle_mem_addr", bus.memory_addr, 0);
        chk("idle_mem_wdata", bus.memory_write_data, 0);
      end
      if (expq.size() == 0) begin
        if (bus.response) chk("spurious_response", {31'b0, bus.response}, 0);
        if (bus.flush_done) chk("spurious_flush_done", {31'b0, bus.flush_done}, 0);
      end else begin
        exp_t e;
        logic ev, other;
        e     = expq[0];
        ev    = e.kind == 2 ? bus.flush_done : bus.response;
        other = e.kind == 2 ? bus.response : bus.flush_done;
        if (other) chk("wrong_completion", {31'b0, other}, 0);
        if (ev) begin
          void'(expq.pop_front());
          if (e.kind == 0) chk("read_data", bus.read_data, e.data);
          chk("mem_reads", rd_cnt - rd_mark, e.nrd);
          chk("mem_writes", wr_cnt - wr_mark, e.nwr);
          rd_mark = rd_cnt;
          wr_mark = wr_cnt;
        end
      end
    end
  end
  initial begin
    #500_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end
  initial begin
    int        cyc, base, r;
    bit        found, rd, wr;
    bit [31:0] a;
    bus.read_request  = 1'b0;
    bus.write_request = 1'b0;
    bus.flush         = 1'b0;
    bus.addr          = 32'h0;
    bus.write_data    = 32'h0;
    bus.write_strb    = 4'h0;
    mem[32'h104] = 32'h1122_3344;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_response", {31'b0, bus.response}, 0);
    chk("rst_flush_done", {31'b0, bus.flush_done}, 0);
    chk("rst_mem_rd", {31'b0, bus.memory_read_request}, 0);
    chk("rst_mem_wr", {31'b0, bus.memory_write_request}, 0);
    chk("rst_mem_addr", bus.memory_addr, 0);
    chk("rst_mem_wdata", bus.memory_write_data, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rd_log.delete();
    issue(1, 0, 32'h100, 0, 0);
    wait_done(0, cyc);
    chk_log("refill_addr_seq", rd_log, 32'h100);
    issue(1, 0, 32'h104, 0, 0);
    wait_done(0, cyc);
    chk("read_hit_latency", cyc, 1);
    issue(0, 1, 32'h104, 32'hAABB_CCDD, 4'b0011);
    wait_done(0, cyc);
    chk("write_hit_latency", cyc, 1);
    issue(1, 0, 32'h104, 0, 0);
    wait_done(0, cyc);
    rd_log.delete();
    wr_log.delete();
    issue(1, 0, 32'h504, 0, 0);
    wait_done(0, cyc);
    chk_log("victim_write_seq", wr_log, 32'h100);
    chk_log("miss_refill_seq", rd_log, 32'h500);
    issue(0, 1, 32'h504, 32'h0BAD_F00D, 4'hF);
    wait_done(0, cyc);
    issue(0, 1, 32'h200, 32'h1357_9BDF, 4'b1100);
    wait_done(0, cyc);
    wr_log.delete();
    do_flush();
    chk("flush_write_count", wr_log.size(), 8);
    do_flush();
    chk("reflush_write_count", wr_log.size(), 8);
    lat_lo = 5;
    lat_hi = 5;
    base = rd_cnt;
    found = 1'b0;
    issue(1, 0, 32'h900, 0, 0);
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      found = rd_cnt == base + 2 && bus.memory_read_request;
    end
    chk("third_refill_word", {31'b0, found}, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_drops_mem_read", {31'b0, bus.memory_read_request}, 0);
    chk("rst_clears_mem_addr", bus.memory_addr, 0);
    bus.read_request = 1'b0;
    expq.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rd_mark = rd_cnt;
    wr_mark = wr_cnt;
    rst_n = 1'b1;
    lat_lo = 0;
    lat_hi = 3;
    rd_log.delete();
    issue(1, 0, 32'h100, 0, 0);
    wait_done(0, cyc);
    chk_log("post_reset_miss", rd_log, 32'h100);
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(99, 0);
      a = ($urandom_range(3, 0) << 10) | ($urandom_range(7, 0) << 4) | ($urandom_range(3, 0) << 2);
      if (r < 5) begin
        do_flush();
      end else begin
        rd = r < 55 || r >= 90;
        wr = r >= 55;
        issue(rd, wr, a, $urandom, 4'($urandom_range(15, 0)));
        wait_done(0, cyc);
      end
    end
    do_flush();
    repeat (3) @(posedge clk);
    chk("scoreboard_drained", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
